// File: rtl/gray_counter.sv
// gray_counter: up/down counter with a registered Gray-coded output.
//
// The count is held as a binary register. The Gray output and the wrap flag
// are registered on the same edge as the binary count, so d_out and bin_out
// always describe the same value and no input reaches an output
// combinationally.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous reset, active low; clears all outputs
//   en       count enable
//   up_dn    direction: 1 = up, 0 = down
//   load     synchronous load of d_in, takes priority over en
//   d_in     Gray-coded load value
//   d_out    registered Gray count, bin ^ (bin >> 1)
//   bin_out  registered binary count
//   wrap     registered one-cycle pulse when the count wraps around
module gray_counter #(
  parameter int unsigned data_width = 4,
  parameter bit          saturate   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [data_width-1:0] d_in,
  output logic [data_width-1:0] d_out,
  output logic [data_width-1:0] bin_out,
  output logic                  wrap
);

  localparam logic [data_width-1:0] CountOne = data_width'(1);
  localparam logic [data_width-1:0] CountMax = '1;
  localparam logic [data_width-1:0] CountMin = '0;

  logic [data_width-1:0] bin_q, bin_d;
  logic [data_width-1:0] gray_q, gray_d;
  logic                  wrap_q, wrap_d;
  logic [data_width-1:0] load_bin;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    load_bin = '0;
    load_bin[data_width-1] = d_in[data_width-1];
    for (int i = int'(data_width) - 2; i >= 0; i--) begin
      load_bin[i] = load_bin[i+1] ^ d_in[i];
    end
  end

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (up_dn) begin
        if (bin_q == CountMax) begin
          if (!saturate) begin
            bin_d  = CountMin;
            wrap_d = 1'b1;
          end
        end else begin
          bin_d = bin_q + CountOne;
        end
      end else begin
        if (bin_q == CountMin) begin
          if (!saturate) begin
            bin_d  = CountMax;
            wrap_d = 1'b1;
          end
        end else begin
          bin_d = bin_q - CountOne;
        end
      end
    end
    // Encode from the next binary value so both output registers track.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign d_out   = gray_q;
  assign bin_out = bin_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: a wrapping and a saturating instance share one set
// of inputs; expected results are queued when stimulus is applied and
// compared after the clock edge that produces them.
module tb_gray_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] d_in;
  logic [3:0] d_out, bin_out;
  logic       wrap;
  logic [3:0] d_out_s, bin_out_s;
  logic       wrap_s;

  gray_counter #(.data_width(4), .saturate(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .d_in(d_in),
    .d_out(d_out), .bin_out(bin_out), .wrap(wrap)
  );

  gray_counter #(.data_width(4), .saturate(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .d_in(d_in),
    .d_out(d_out_s), .bin_out(bin_out_s), .wrap(wrap_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] bin;
    logic       wrp;
    logic [3:0] bin_s;
    logic       wrp_s;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [3:0] m_bin, m_bin_s;
  logic [3:0] sweep_gray [16];
  logic [3:0] prev_gray;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] from_gray(input logic [3:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  task automatic model(input logic [3:0] b, input bit sat, input logic ld,
                       input logic [3:0] di, input logic e, input logic u,
                       output logic [3:0] nb, output logic nw);
    nb = b;
    nw = 1'b0;
    if (ld) nb = from_gray(di);
    else if (e && u) begin
      if (b == 4'd15) begin
        if (!sat) begin nb = 4'd0; nw = 1'b1; end
      end else nb = b + 4'd1;
    end else if (e) begin
      if (b == 4'd0) begin
        if (!sat) begin nb = 4'd15; nw = 1'b1; end
      end else nb = b - 4'd1;
    end
  endtask

  // Apply one cycle of stimulus, queue the model's prediction, then compare
  // just after the edge.
  task automatic step(input logic ld, input logic [3:0] di, input logic e, input logic u);
    exp_t ex;
    logic [3:0] nb;
    logic nw;
    load  = ld;
    d_in  = di;
    en    = e;
    up_dn = u;
    model(m_bin, 1'b0, ld, di, e, u, nb, nw);
    m_bin = nb; ex.bin = nb; ex.wrp = nw;
    model(m_bin_s, 1'b1, ld, di, e, u, nb, nw);
    m_bin_s = nb; ex.bin_s = nb; ex.wrp_s = nw;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      ex = exp_q.pop_front();
      check("bin", 32'(bin_out), 32'(ex.bin));
      check("gray", 32'(d_out), 32'(to_gray(ex.bin)));
      check("wrap", 32'(wrap), 32'(ex.wrp));
      check("sat_bin", 32'(bin_out_s), 32'(ex.bin_s));
      check("sat_gray", 32'(d_out_s), 32'(to_gray(ex.bin_s)));
      check("sat_wrap", 32'(wrap_s), 32'(ex.wrp_s));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sweep_gray = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                   4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001,
                   4'b1000, 4'b0000};
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; d_in = 4'd0;
    m_bin = 4'd0; m_bin_s = 4'd0;
    #3;
    check("reset_gray", 32'(d_out), 32'd0);
    check("reset_bin", 32'(bin_out), 32'd0);
    check("reset_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Up sweep from 0 through the wrap.
    prev_gray = d_out;
    check("sweep_start", 32'(d_out), 32'd0);
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 4'd0, 1'b1, 1'b1);
      check("sweep_table", 32'(d_out), 32'(sweep_gray[k]));
      check("sweep_hamming", 32'($countones(d_out ^ prev_gray)), 32'd1);
      prev_gray = d_out;
    end
    check("sweep_wrap", 32'(wrap), 32'd1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    check("sweep_wrap_gone", 32'(wrap), 32'd0);

    // Load then count down.
    step(1'b1, 4'b1100, 1'b0, 1'b0);
    check("load_bin8", 32'(bin_out), 32'd8);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("down_bin7", 32'(bin_out), 32'd7);
    check("down_gray", 32'(d_out), 32'b0100);

    // Down wrap from 0; saturating instance stays at 0.
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0);
    check("dwrap_bin", 32'(bin_out), 32'd15);
    check("dwrap_gray", 32'(d_out), 32'b1000);
    check("dwrap_pulse", 32'(wrap), 32'd1);
    check("sat_hold_zero", 32'(bin_out_s), 32'd0);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    check("dwrap_pulse_gone", 32'(wrap), 32'd0);

    // Saturating instance holds at 15 going up.
    step(1'b1, 4'b1000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'd0, 1'b1, 1'b1);
      check("sat_top_gray", 32'(d_out_s), 32'b1000);
      check("sat_top_wrap", 32'(wrap_s), 32'd0);
    end

    // Load has priority over en.
    step(1'b1, 4'b0111, 1'b0, 1'b0);
    check("prio_pre", 32'(bin_out), 32'd5);
    step(1'b1, 4'b0011, 1'b1, 1'b1);
    check("prio_bin", 32'(bin_out), 32'd2);
    for (int k = 0; k < 4; k++) step(1'b0, 4'd0, 1'b0, 1'b1);
    check("prio_hold", 32'(d_out), 32'b0011);

    // Random mix of load/enable/direction.
    for (int k = 0; k < 40; k++) begin
      step(($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-count from 9.
    step(1'b1, 4'b1101, 1'b0, 1'b0);
    check("pre_reset_bin9", 32'(bin_out), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_gray", 32'(d_out), 32'd0);
    check("async_bin", 32'(bin_out), 32'd0);
    check("async_wrap", 32'(wrap), 32'd0);
    check("async_sat_bin", 32'(bin_out_s), 32'd0);
    #1;
    rst_n = 1'b1;
    m_bin = 4'd0; m_bin_s = 4'd0;
    step(1'b0, 4'd0, 1'b1, 1'b1);
    check("resume_bin1", 32'(bin_out), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
